demux8x8_stream: RTL and testbench

DEMUX8X8_STREAM -- requirements
Module: demux8x8_stream

---
 rtl/demux8x8_stream.sv | 118 +++++++++++
 tb/tb_demux8x8_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux8x8_stream.sv
// Stream demultiplexer: a 2-entry in-order FIFO of {data, sel} whose head word
// is presented to the one output channel named by its select.
module demux8x8_stream #(
  parameter int WIDTH    = 8,
  parameter int SEL_BITS = 3,
  localparam int N       = 2 ** SEL_BITS
) (
  input  logic                CLK,
  input  logic                ASYNCRESETN,
  input  logic [WIDTH-1:0]    I,
  input  logic [SEL_BITS-1:0] S,
  input  logic                I_valid,
  output logic                I_ready,
  output logic [WIDTH-1:0]    O,
  output logic [N-1:0]        O_valid,
  input  logic [N-1:0]        O_ready,
  output logic [15:0]         xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [N-1:0] LSB_SET = {{(N-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    head_data_q, head_data_d;
  logic [SEL_BITS-1:0] head_sel_q, head_sel_d;
  logic [WIDTH-1:0]    tail_data_q, tail_data_d;
  logic [SEL_BITS-1:0] tail_sel_q, tail_sel_d;
  logic [15:0]         cnt_q, cnt_d;
  // Keeps I_ready low during reset and until the first clock edge after release.
  logic                rdy_en_q, rdy_en_d;

  logic head_valid;
  logic push;
  logic pop;

  always_comb begin
    head_valid = (state_q != EMPTY);
    I_ready    = rdy_en_q && (state_q != TWO);
    O_valid    = head_valid ? (LSB_SET << head_sel_q) : '0;
    O          = head_valid ? head_data_q : '0;
    xfer_cnt   = cnt_q;
    push       = I_valid && I_ready;
    // Only the head channel's ready matters; other channels wait behind it.
    pop        = head_valid && O_ready[head_sel_q];
  end

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    tail_data_d = tail_data_q;
    tail_sel_d  = tail_sel_q;
    cnt_d       = cnt_q;
    rdy_en_d    = 1'b1;

    if (pop) begin
      cnt_d = cnt_q + 16'd1;
    end

    case (state_q)
      EMPTY: begin
        if (push) begin
          head_data_d = I;
          head_sel_d  = S;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_data_d = I;
          head_sel_d  = S;
        end else if (push) begin
          tail_data_d = I;
          tail_sel_d  = S;
          state_d     = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_sel_d  = tail_sel_q;
          state_d     = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_sel_q  <= '0;
      tail_data_q <= '0;
      tail_sel_q  <= '0;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      tail_data_q <= tail_data_d;
      tail_sel_q  <= tail_sel_d;
      cnt_q       <= cnt_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_demux8x8_stream.sv
// Directed bench for demux8x8_stream: hand-computed expectations for transfer,
// backpressure, throughput, head-of-line blocking, reset and counter wrap.
module tb_demux8x8_stream;

  logic        CLK;
  logic        ASYNCRESETN;
  logic [7:0]  I;
  logic [2:0]  S;
  logic        I_valid;
  logic        I_ready;
  logic [7:0]  O;
  logic [7:0]  O_valid;
  logic [7:0]  O_ready;
  logic [15:0] xfer_cnt;

  int checks_cnt;
  int errors_cnt;
  int exp_cnt;

  demux8x8_stream #(.WIDTH(8), .SEL_BITS(3)) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .I          (I),
    .S          (S),
    .I_valid    (I_valid),
    .I_ready    (I_ready),
    .O          (O),
    .O_valid    (O_valid),
    .O_ready    (O_ready),
    .xfer_cnt   (xfer_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one edge, then settle just past it so outputs are sampled off-edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    exp_cnt     = 0;
    ASYNCRESETN = 1'b0;
    I           = '0;
    S           = '0;
    I_valid     = 1'b0;
    O_ready     = 8'hFF;

    // Reset hold, including edges while asserted.
    step();
    step();
    check_val("rst_ovalid", 32'(O_valid), 32'h0);
    check_val("rst_iready", 32'(I_ready), 32'h0);
    check_val("rst_o", 32'(O), 32'h0);
    check_val("rst_cnt", 32'(xfer_cnt), 32'h0);
    ASYNCRESETN = 1'b1;
    #1;
    check_val("rel_iready_pre_edge", 32'(I_ready), 32'h0);
    step();
    check_val("rel_iready_first_edge", 32'(I_ready), 32'h1);

    // Single transfer.
    O_ready = 8'hFF; I = 8'hA5; S = 3'd3; I_valid = 1'b1;
    step();
    I_valid = 1'b0;
    check_val("single_o", 32'(O), 32'hA5);
    check_val("single_ovalid", 32'(O_valid), 32'h08);
    step();
    exp_cnt = 1;
    check_val("single_ovalid_drop", 32'(O_valid), 32'h0);
    check_val("single_cnt", 32'(xfer_cnt), 32'(exp_cnt));

    // Backpressure fill.
    O_ready = 8'h00; I = 8'h11; S = 3'd0; I_valid = 1'b1;
    step();
    check_val("bp_one_iready", 32'(I_ready), 32'h1);
    check_val("bp_one_ovalid", 32'(O_valid), 32'h01);
    I = 8'h22; S = 3'd7;
    step();
    I_valid = 1'b0;
    check_val("bp_two_iready", 32'(I_ready), 32'h0);
    check_val("bp_two_ovalid", 32'(O_valid), 32'h01);
    check_val("bp_two_o", 32'(O), 32'h11);
    step();
    check_val("bp_hold_ovalid", 32'(O_valid), 32'h01);
    check_val("bp_hold_o", 32'(O), 32'h11);
    O_ready = 8'h01;
    step();
    exp_cnt++;
    check_val("bp_pop_ovalid", 32'(O_valid), 32'h80);
    check_val("bp_pop_o", 32'(O), 32'h22);
    check_val("bp_pop_iready", 32'(I_ready), 32'h1);
    check_val("bp_pop_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    O_ready = 8'hFF;
    step();
    exp_cnt++;
    check_val("bp_drain_ovalid", 32'(O_valid), 32'h0);

    // Full throughput: one word per cycle, O_valid walking one bit per cycle.
    O_ready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      I = 8'(k); S = 3'(k); I_valid = 1'b1;
      step();
      check_val($sformatf("tput_ovalid_%0d", k), 32'(O_valid), 32'h1 << k);
      check_val($sformatf("tput_o_%0d", k), 32'(O), 32'(k));
      check_val($sformatf("tput_iready_%0d", k), 32'(I_ready), 32'h1);
    end
    I_valid = 1'b0;
    step();
    exp_cnt += 8;
    check_val("tput_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    check_val("tput_empty", 32'(O_valid), 32'h0);

    // Head-of-line blocking: head for channel 2 stalls a later word for channel 5.
    O_ready = 8'hFB; I = 8'h5C; S = 3'd2; I_valid = 1'b1;
    step();
    I = 8'h6D; S = 3'd5;
    step();
    I_valid = 1'b0;
    step();
    step();
    check_val("hol_o", 32'(O), 32'h5C);
    check_val("hol_ovalid", 32'(O_valid), 32'h04);
    check_val("hol_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    check_val("hol_iready", 32'(I_ready), 32'h0);
    O_ready = 8'hFF;
    step();
    exp_cnt++;
    check_val("hol_next_ovalid", 32'(O_valid), 32'h20);
    check_val("hol_next_o", 32'(O), 32'h6D);
    step();
    exp_cnt++;
    check_val("hol_drain_cnt", 32'(xfer_cnt), 32'(exp_cnt));

    // Mid-operation reset with the FIFO full.
    O_ready = 8'h00; I = 8'h33; S = 3'd1; I_valid = 1'b1;
    step();
    I = 8'h44; S = 3'd6;
    step();
    I_valid = 1'b0;
    check_val("mrst_full_iready", 32'(I_ready), 32'h0);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    check_val("mrst_ovalid", 32'(O_valid), 32'h0);
    check_val("mrst_cnt", 32'(xfer_cnt), 32'h0);
    check_val("mrst_o", 32'(O), 32'h0);
    check_val("mrst_iready", 32'(I_ready), 32'h0);
    #1;
    ASYNCRESETN = 1'b1;
    O_ready = 8'hFF;
    exp_cnt = 0;
    step();
    check_val("mrst_rel_ovalid", 32'(O_valid), 32'h0);
    check_val("mrst_rel_iready", 32'(I_ready), 32'h1);
    step();
    check_val("mrst_rel_ovalid2", 32'(O_valid), 32'h0);
    check_val("mrst_rel_cnt", 32'(xfer_cnt), 32'h0);

    // Counter wrap: 65536 words streamed back-to-back.
    O_ready = 8'hFF; I_valid = 1'b1;
    for (int n = 0; n < 65536; n++) begin
      I = 8'(n); S = 3'(n);
      step();
    end
    I_valid = 1'b0;
    check_val("wrap_cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
    check_val("wrap_last_o", 32'(O), 32'hFF);
    step();
    check_val("wrap_cnt_zero", 32'(xfer_cnt), 32'h0);
    check_val("wrap_empty", 32'(O_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
